seq_alu_md: RTL

- Parametrised multi-cycle execution unit: RV32I/RV64I base ALU ops plus RISC-V M-extension multiply, divide and remainder.
- Sits in the EX stage of the next-generation core, behind a start/done handshake; the pipeline stalls while busy is high.
- Base ops complete in 1 cycle. M ops are iterative, one bit per cycle: shift-add multiply, restoring divide.

---
 rtl/seq_alu_md.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu_md.sv
// Multi-cycle RV32I/RV64I ALU plus M-extension mul/div/rem behind a start/done handshake.
// Define SEQ_ALU_MD_EARLY_OUT_EN to let trivial M ops (b==0, or a==0 for mul*) skip the iterative phase.
module seq_alu_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ltu,
    output logic             geu
);
    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mop;
    logic [WIDTH-1:0] a_q, b_q, mag_b, hi, lo;
    logic             neg_q, sa_q;

    logic             is_m, signed_a, signed_b, sa, sb, early;
    logic [WIDTH-1:0] mag_a, alu_res, fin_res, quo, rmd;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic             div_ok, ovf;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign busy = (state != IDLE);
    assign is_m = (op[4:3] == 2'b10);

    // Signedness of each operand for the M ops, keyed by op[2:0]
    assign signed_a = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                      (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    assign signed_b = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    assign sa       = signed_a & a[WIDTH-1];
    assign sb       = signed_b & b[WIDTH-1];
    assign mag_a    = sa ? -a : a;

`ifdef SEQ_ALU_MD_EARLY_OUT_EN
    assign early = (b == '0) || (!op[2] && (a == '0));
`else
    assign early = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            5'b00000: alu_res = a + b;
            5'b00001: alu_res = a - b;
            5'b00010: alu_res = a & b;
            5'b00011: alu_res = a | b;
            5'b00100: alu_res = a << b[SH_W-1:0];
            5'b00101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            5'b00110: alu_res = a ^ b;
            5'b00111: alu_res = a >> b[SH_W-1:0];
            5'b01000: alu_res = $signed(a) >>> b[SH_W-1:0];
            5'b01001: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  alu_res = '0;
        endcase
    end

    // hi:lo is the shift-add product register for mul, remainder:quotient for div
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    assign div_sh  = {hi, lo[WIDTH-1]};
    assign div_ok  = (div_sh >= {1'b0, mag_b});

    assign prod   = {hi, lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = neg_q ? -lo : lo;
    assign rmd    = sa_q ? -hi : hi;
    assign ovf    = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        fin_res = '0;
        case (mop)
            3'b000:  fin_res = prod_s[WIDTH-1:0];
            3'b001,
            3'b010,
            3'b011:  fin_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100:  fin_res = (b_q == '0) ? '1 : (ovf ? a_q : quo);
            3'b101:  fin_res = (b_q == '0) ? '1 : lo;
            3'b110:  fin_res = (b_q == '0) ? a_q : (ovf ? '0 : rmd);
            default: fin_res = (b_q == '0) ? a_q : hi;
        endcase
        // An early-out mul with b==0 never clears lo, so force the zero product
        if (!mop[2] && ((a_q == '0) || (b_q == '0)))
            fin_res = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && is_m) state_nxt = early ? FIN : RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            ltu    <= 1'b0;
            geu    <= 1'b0;
            cnt    <= '0;
            mop    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mag_b  <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_m) begin
                        mop   <= op[2:0];
                        a_q   <= a;
                        b_q   <= b;
                        mag_b <= sb ? -b : b;
                        hi    <= '0;
                        lo    <= mag_a;
                        cnt   <= '0;
                        neg_q <= sa ^ sb;
                        sa_q  <= sa;
                    end else if (start) begin
                        result <= alu_res;
                        zero   <= (alu_res == '0);
                        ltu    <= (a < b);
                        geu    <= (a >= b);
                        done   <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!mop[2]) begin
                        hi <= mul_sum[WIDTH:1];
                        lo <= {mul_sum[0], lo[WIDTH-1:1]};
                    end else begin
                        hi <= div_ok ? (div_sh[WIDTH-1:0] - mag_b) : div_sh[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], div_ok};
                    end
                end
                FIN: begin
                    result <= fin_res;
                    zero   <= (fin_res == '0);
                    ltu    <= (a_q < b_q);
                    geu    <= (a_q >= b_q);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
